id_ex_reg: RTL and testbench

ID_EX_REG -- requirements
Module: id_ex_reg

---
 rtl/id_ex_reg.sv | 124 ++++++++++++
 tb/tb_id_ex_reg.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: load-use stall detection, writeback-to-decode
// operand bypass, flush squashing and a saturating count of inserted bubbles.
module id_ex_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic [4:0]       id_rd,
  input  logic [WIDTH-1:0] id_data1,
  input  logic [WIDTH-1:0] id_data2,
  input  logic [WIDTH-1:0] id_imm,
  input  logic [7:0]       id_ctrl,
  input  logic             flush,
  input  logic             wb_regwrite,
  input  logic [4:0]       wb_addr,
  input  logic [WIDTH-1:0] wb_data,
  output logic             ex_valid,
  output logic [4:0]       ex_rs,
  output logic [4:0]       ex_rt,
  output logic [4:0]       ex_dest,
  output logic [WIDTH-1:0] ex_data1,
  output logic [WIDTH-1:0] ex_data2,
  output logic [WIDTH-1:0] ex_imm,
  output logic [7:0]       ex_ctrl,
  output logic             stall,
  output logic [15:0]      bubble_cnt
);

  // state | meaning
  // RUN   | normal issue; load-use hazards may raise stall
  // HOLD  | bubble just inserted for a load-use; stall suppressed one cycle
  typedef enum logic {RUN = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [15:0] CNT_MAX = 16'hFFFF;

  state_t           state_q, state_d;
  logic             ex_valid_q, ex_valid_d;
  logic [4:0]       ex_rs_q, ex_rs_d;
  logic [4:0]       ex_rt_q, ex_rt_d;
  logic [4:0]       ex_dest_q, ex_dest_d;
  logic [WIDTH-1:0] ex_data1_q, ex_data1_d;
  logic [WIDTH-1:0] ex_data2_q, ex_data2_d;
  logic [WIDTH-1:0] ex_imm_q, ex_imm_d;
  logic [7:0]       ex_ctrl_q, ex_ctrl_d;
  logic [15:0]      bubble_cnt_q, bubble_cnt_d;

  logic hazard;
  logic stall_int;
  logic insert_bubble;
  logic byp1;
  logic byp2;

  always_comb begin
    hazard = ex_valid_q & ex_ctrl_q[6] & id_valid & (ex_rt_q != 5'd0) &
             ((ex_rt_q == id_rs) | (ex_rt_q == id_rt));
    // A redirect overrides the hazard: the dependent instruction is squashed
    // anyway, so PC and IF/ID must be free to take the new target.
    stall_int = hazard & ~rst & ~flush & (state_q == RUN);
    insert_bubble = flush | stall_int | ~id_valid;

    byp1 = wb_regwrite & (wb_addr != 5'd0) & (wb_addr == id_rs);
    byp2 = wb_regwrite & (wb_addr != 5'd0) & (wb_addr == id_rt);

    state_d = state_q;
    case (state_q)
      RUN:     if (stall_int) state_d = HOLD;
      HOLD:    state_d = RUN;
      default: state_d = RUN;
    endcase

    ex_valid_d = ~insert_bubble;
    ex_ctrl_d  = insert_bubble ? 8'h00 : id_ctrl;
    ex_rs_d    = id_rs;
    ex_rt_d    = id_rt;
    ex_dest_d  = id_ctrl[2] ? id_rd : id_rt;
    ex_imm_d   = id_imm;
    ex_data1_d = byp1 ? wb_data : id_data1;
    ex_data2_d = byp2 ? wb_data : id_data2;

    bubble_cnt_d = bubble_cnt_q;
    if (stall_int && (bubble_cnt_q != CNT_MAX)) bubble_cnt_d = bubble_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      ex_valid_q   <= 1'b0;
      ex_ctrl_q    <= '0;
      ex_rs_q      <= '0;
      ex_rt_q      <= '0;
      ex_dest_q    <= '0;
      ex_data1_q   <= '0;
      ex_data2_q   <= '0;
      ex_imm_q     <= '0;
      bubble_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      ex_valid_q   <= ex_valid_d;
      ex_ctrl_q    <= ex_ctrl_d;
      ex_rs_q      <= ex_rs_d;
      ex_rt_q      <= ex_rt_d;
      ex_dest_q    <= ex_dest_d;
      ex_data1_q   <= ex_data1_d;
      ex_data2_q   <= ex_data2_d;
      ex_imm_q     <= ex_imm_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign ex_valid   = ex_valid_q;
  assign ex_rs      = ex_rs_q;
  assign ex_rt      = ex_rt_q;
  assign ex_dest    = ex_dest_q;
  assign ex_data1   = ex_data1_q;
  assign ex_data2   = ex_data2_q;
  assign ex_imm     = ex_imm_q;
  assign ex_ctrl    = ex_ctrl_q;
  assign stall      = stall_int;
  assign bubble_cnt = bubble_cnt_q;

endmodule

// File: tb/tb_id_ex_reg.sv
// Directed bench for id_ex_reg: reset, pass-through, bypass, load-use,
// flush priority, reset during HOLD and bubble counter saturation.
module tb_id_ex_reg;
  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic             id_valid;
  logic [4:0]       id_rs, id_rt, id_rd;
  logic [WIDTH-1:0] id_data1, id_data2, id_imm;
  logic [7:0]       id_ctrl;
  logic             flush;
  logic             wb_regwrite;
  logic [4:0]       wb_addr;
  logic [WIDTH-1:0] wb_data;
  logic             ex_valid;
  logic [4:0]       ex_rs, ex_rt, ex_dest;
  logic [WIDTH-1:0] ex_data1, ex_data2, ex_imm;
  logic [7:0]       ex_ctrl;
  logic             stall;
  logic [15:0]      bubble_cnt;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [15:0] exp_cnt  = 16'd0;

  always #5 clk = ~clk;

  id_ex_reg #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_data1(id_data1), .id_data2(id_data2), .id_imm(id_imm),
    .id_ctrl(id_ctrl), .flush(flush),
    .wb_regwrite(wb_regwrite), .wb_addr(wb_addr), .wb_data(wb_data),
    .ex_valid(ex_valid), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dest(ex_dest),
    .ex_data1(ex_data1), .ex_data2(ex_data2), .ex_imm(ex_imm),
    .ex_ctrl(ex_ctrl), .stall(stall), .bubble_cnt(bubble_cnt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                          input logic [4:0] rd, input logic [7:0] ctrl,
                          input logic [WIDTH-1:0] d1, input logic [WIDTH-1:0] d2,
                          input logic [WIDTH-1:0] imm);
    id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_ctrl = ctrl;
    id_data1 = d1; id_data2 = d2; id_imm = imm;
  endtask

  task automatic idle();
    drive_id(1'b0, 5'd0, 5'd0, 5'd0, 8'h00, '0, '0, '0);
    flush = 1'b0; wb_regwrite = 1'b0; wb_addr = 5'd0; wb_data = '0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive_id(1'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 8'($urandom),
               $urandom, $urandom, $urandom);
      flush = 1'($urandom); wb_regwrite = 1'($urandom);
      wb_addr = 5'($urandom); wb_data = $urandom;
      step();
    end
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid got=%0h exp=0", ex_valid); end
    n_checks++; if (ex_ctrl !== 8'h00) begin n_fail++; $display("FAIL rst_ctrl got=%0h exp=0", ex_ctrl); end
    n_checks++; if ({ex_rs, ex_rt, ex_dest} !== 15'd0) begin n_fail++; $display("FAIL rst_addr got=%0h exp=0", {ex_rs, ex_rt, ex_dest}); end
    n_checks++; if ({ex_data1, ex_data2, ex_imm} !== '0) begin n_fail++; $display("FAIL rst_data got=%0h/%0h/%0h exp=0", ex_data1, ex_data2, ex_imm); end
    n_checks++; if (bubble_cnt !== 16'd0) begin n_fail++; $display("FAIL rst_cnt got=%0h exp=0", bubble_cnt); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall got=%0h exp=0", stall); end
    rst = 1'b0;
    idle();
    step();
  endtask

  task automatic test_pass_through();
    drive_id(1'b1, 5'd3, 5'd4, 5'd5, 8'h84, 32'h11, 32'h22, 32'h33);
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL pass_stall got=%0h exp=0", stall); end
    step();
    n_checks++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL pass_valid got=%0h exp=1", ex_valid); end
    n_checks++; if (ex_dest !== 5'd5) begin n_fail++; $display("FAIL pass_dest got=%0d exp=5", ex_dest); end
    n_checks++; if (ex_data1 !== 32'h11) begin n_fail++; $display("FAIL pass_data1 got=%0h exp=11", ex_data1); end
    n_checks++; if (ex_data2 !== 32'h22) begin n_fail++; $display("FAIL pass_data2 got=%0h exp=22", ex_data2); end
    n_checks++; if ({ex_rs, ex_rt} !== {5'd3, 5'd4}) begin n_fail++; $display("FAIL pass_rsrt got=%0d/%0d exp=3/4", ex_rs, ex_rt); end
    n_checks++; if (ex_ctrl !== 8'h84) begin n_fail++; $display("FAIL pass_ctrl got=%0h exp=84", ex_ctrl); end
    n_checks++; if (ex_imm !== 32'h33) begin n_fail++; $display("FAIL pass_imm got=%0h exp=33", ex_imm); end
    // regdst = 0 selects rt as destination
    drive_id(1'b1, 5'd1, 5'd6, 5'd9, 8'h82, 32'hA, 32'hB, 32'hC);
    step();
    n_checks++; if (ex_dest !== 5'd6) begin n_fail++; $display("FAIL pass_dest_rt got=%0d exp=6", ex_dest); end
    n_checks++; if (ex_ctrl !== 8'h82) begin n_fail++; $display("FAIL pass_ctrl2 got=%0h exp=82", ex_ctrl); end
    drive_id(1'b0, 5'd1, 5'd2, 5'd3, 8'hFF, 32'h1, 32'h2, 32'h3);
    step();
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL idle_valid got=%0h exp=0", ex_valid); end
    n_checks++; if (ex_ctrl !== 8'h00) begin n_fail++; $display("FAIL idle_ctrl got=%0h exp=0", ex_ctrl); end
  endtask

  task automatic test_bypass();
    wb_regwrite = 1'b1; wb_addr = 5'd7; wb_data = 32'hCAFE;
    drive_id(1'b1, 5'd1, 5'd7, 5'd2, 8'h84, 32'h55, 32'h0, 32'h0);
    step();
    n_checks++; if (ex_data2 !== 32'hCAFE) begin n_fail++; $display("FAIL byp_rt got=%0h exp=cafe", ex_data2); end
    n_checks++; if (ex_data1 !== 32'h55) begin n_fail++; $display("FAIL byp_rs_nomatch got=%0h exp=55", ex_data1); end
    wb_addr = 5'd0;
    drive_id(1'b1, 5'd0, 5'd0, 5'd2, 8'h84, 32'h77, 32'h1234, 32'h0);
    step();
    n_checks++; if (ex_data2 !== 32'h1234) begin n_fail++; $display("FAIL byp_zero_rt got=%0h exp=1234", ex_data2); end
    n_checks++; if (ex_data1 !== 32'h77) begin n_fail++; $display("FAIL byp_zero_rs got=%0h exp=77", ex_data1); end
    wb_addr = 5'd3; wb_data = 32'hBEEF;
    drive_id(1'b1, 5'd3, 5'd4, 5'd2, 8'h84, 32'h99, 32'h88, 32'h0);
    step();
    n_checks++; if (ex_data1 !== 32'hBEEF) begin n_fail++; $display("FAIL byp_rs got=%0h exp=beef", ex_data1); end
    n_checks++; if (ex_data2 !== 32'h88) begin n_fail++; $display("FAIL byp_rt_nomatch got=%0h exp=88", ex_data2); end
    wb_regwrite = 1'b0;
    step();
    n_checks++; if (ex_data1 !== 32'h99) begin n_fail++; $display("FAIL byp_no_we got=%0h exp=99", ex_data1); end
    idle();
    step();
  endtask

  task automatic test_load_use();
    drive_id(1'b1, 5'd1, 5'd8, 5'd0, 8'hD0, 32'h0, 32'h0, 32'h4);
    step();
    drive_id(1'b1, 5'd8, 5'd2, 5'd3, 8'h84, 32'h10, 32'h20, 32'h0);
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_stall got=%0h exp=1", stall); end
    step();
    exp_cnt = exp_cnt + 16'd1;
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL lu_bubble got=%0h exp=0", ex_valid); end
    n_checks++; if (bubble_cnt !== exp_cnt) begin n_fail++; $display("FAIL lu_cnt got=%0h exp=%0h", bubble_cnt, exp_cnt); end
    n_checks++; if (dut.state_q !== 1'b1) begin n_fail++; $display("FAIL lu_hold got=%0h exp=1", dut.state_q); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_stall_hold got=%0h exp=0", stall); end
    step();
    n_checks++; if ({ex_valid, ex_rs} !== {1'b1, 5'd8}) begin n_fail++; $display("FAIL lu_issue got=%0h/%0d exp=1/8", ex_valid, ex_rs); end
    n_checks++; if (dut.state_q !== 1'b0) begin n_fail++; $display("FAIL lu_run got=%0h exp=0", dut.state_q); end
    n_checks++; if (bubble_cnt !== exp_cnt) begin n_fail++; $display("FAIL lu_cnt_hold got=%0h exp=%0h", bubble_cnt, exp_cnt); end
    // hazard through the rt operand
    drive_id(1'b1, 5'd0, 5'd12, 5'd0, 8'hD0, 32'h0, 32'h0, 32'h0);
    step();
    drive_id(1'b1, 5'd1, 5'd12, 5'd3, 8'h84, 32'h0, 32'h0, 32'h0);
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lu_rt_stall got=%0h exp=1", stall); end
    step();
    exp_cnt = exp_cnt + 16'd1;
    step();
    n_checks++; if (bubble_cnt !== exp_cnt) begin n_fail++; $display("FAIL lu_rt_cnt got=%0h exp=%0h", bubble_cnt, exp_cnt); end
    // load into r0 never creates a hazard
    drive_id(1'b1, 5'd0, 5'd0, 5'd0, 8'hD0, 32'h0, 32'h0, 32'h0);
    step();
    drive_id(1'b1, 5'd0, 5'd0, 5'd3, 8'h84, 32'h0, 32'h0, 32'h0);
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lu_r0_stall got=%0h exp=0", stall); end
    step();
    n_checks++; if (ex_valid !== 1'b1) begin n_fail++; $display("FAIL lu_r0_issue got=%0h exp=1", ex_valid); end
    idle();
    step();
  endtask

  task automatic test_flush_vs_stall();
    drive_id(1'b1, 5'd0, 5'd9, 5'd0, 8'hD0, 32'h0, 32'h0, 32'h0);
    step();
    drive_id(1'b1, 5'd9, 5'd1, 5'd3, 8'h84, 32'h0, 32'h0, 32'h0);
    flush = 1'b1;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL fl_stall got=%0h exp=0", stall); end
    step();
    n_checks++; if (ex_valid !== 1'b0) begin n_fail++; $display("FAIL fl_valid got=%0h exp=0", ex_valid); end
    n_checks++; if (bubble_cnt !== exp_cnt) begin n_fail++; $display("FAIL fl_cnt got=%0h exp=%0h", bubble_cnt, exp_cnt); end
    n_checks++; if (dut.state_q !== 1'b0) begin n_fail++; $display("FAIL fl_state got=%0h exp=0", dut.state_q); end
    idle();
    step();
  endtask

  task automatic test_reset_mid_stall();
    drive_id(1'b1, 5'd0, 5'd11, 5'd0, 8'hD0, 32'h0, 32'h0, 32'h0);
    step();
    drive_id(1'b1, 5'd11, 5'd1, 5'd3, 8'h84, 32'h5, 32'h6, 32'h0);
    step();
    exp_cnt = exp_cnt + 16'd1;
    n_checks++; if (bubble_cnt !== exp_cnt) begin n_fail++; $display("FAIL rm_cnt got=%0h exp=%0h", bubble_cnt, exp_cnt); end
    rst = 1'b1;
    step();
    exp_cnt = 16'd0;
    n_checks++; if (dut.state_q !== 1'b0) begin n_fail++; $display("FAIL rm_state got=%0h exp=0", dut.state_q); end
    n_checks++; if ({ex_valid, bubble_cnt} !== 17'd0) begin n_fail++; $display("FAIL rm_clear got=%0h/%0h exp=0/0", ex_valid, bubble_cnt); end
    rst = 1'b0;
    #1;
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rm_stall got=%0h exp=0", stall); end
    step();
    n_checks++; if ({ex_valid, ex_ctrl, ex_rs} !== {1'b1, 8'h84, 5'd11}) begin n_fail++; $display("FAIL rm_issue got=%0h/%0h/%0d exp=1/84/11", ex_valid, ex_ctrl, ex_rs); end
    idle();
    step();
  endtask

  task automatic test_saturation();
    // Preload near the top; 65535 real stalls would need ~131k cycles.
    force dut.bubble_cnt_q = 16'hFFFD;
    step();
    release dut.bubble_cnt_q;
    exp_cnt = 16'hFFFD;
    n_checks++; if (bubble_cnt !== exp_cnt) begin n_fail++; $display("FAIL sat_preload got=%0h exp=%0h", bubble_cnt, exp_cnt); end
    for (int i = 0; i < 4; i++) begin
      drive_id(1'b1, 5'd0, 5'd8, 5'd0, 8'hD0, 32'h0, 32'h0, 32'h0);
      step();
      drive_id(1'b1, 5'd8, 5'd1, 5'd3, 8'h84, 32'h0, 32'h0, 32'h0);
      #1;
      n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL sat_stall[%0d] got=%0h exp=1", i, stall); end
      step();
      if (exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
      n_checks++; if (bubble_cnt !== exp_cnt) begin n_fail++; $display("FAIL sat_cnt[%0d] got=%0h exp=%0h", i, bubble_cnt, exp_cnt); end
      step();
    end
    n_checks++; if (bubble_cnt !== 16'hFFFF) begin n_fail++; $display("FAIL sat_final got=%0h exp=ffff", bubble_cnt); end
    idle();
    step();
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_pass_through();
    test_bypass();
    test_load_use();
    test_flush_vs_stall();
    test_reset_mid_stall();
    test_saturation();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
